// File: rtl/pool_channel_scheduler.sv
// Feeds num_channels frames through a pooling core, one channel at a time, and
// tags every pooled result with its channel index and an end-of-channel flag.
module pool_channel_scheduler #(
  parameter int INPUT_X  = 5,
  parameter int INPUT_Y  = 5,
  parameter int OUT_X    = 3,
  parameter int OUT_Y    = 3,
  parameter int CH_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CH_WIDTH-1:0] num_channels,
  output logic                busy,
  output logic                done,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [31:0]         src_data,
  output logic                core_sof,
  output logic                core_input_valid,
  output logic [31:0]         core_d_in,
  input  logic                core_output_valid,
  input  logic [31:0]         core_d_out,
  output logic                out_valid,
  output logic [31:0]         out_data,
  output logic [CH_WIDTH-1:0] out_channel,
  output logic                out_last
);

  localparam int IN_TOTAL  = INPUT_X * INPUT_Y;
  localparam int OUT_TOTAL = OUT_X * OUT_Y;
  localparam int CNT_MAX   = (IN_TOTAL > OUT_TOTAL) ? IN_TOTAL : OUT_TOTAL;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    IN_LAST  = CNT_W'(IN_TOTAL - 1);
  localparam logic [CNT_W-1:0]    OUT_LAST = CNT_W'(OUT_TOTAL - 1);
  localparam logic [CNT_W-1:0]    OUT_TERM = CNT_W'(OUT_TOTAL);
  localparam logic [CH_WIDTH-1:0] CH_ONE   = CH_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, FIN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [CH_WIDTH-1:0] ch_idx_q, ch_idx_d;
  logic [CH_WIDTH-1:0] num_ch_q, num_ch_d;

  logic                done_q;
  logic                core_sof_q, core_iv_q;
  logic [31:0]         core_d_in_q;
  logic                out_valid_q, out_last_q;
  logic [31:0]         out_data_q;
  logic [CH_WIDTH-1:0] out_channel_q;

  logic accept;
  logic res_ok;

  assign accept = src_valid && (state_q == FEED);
  assign res_ok = core_output_valid && ((state_q == FEED) || (state_q == DRAIN));

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ch_idx_d  = ch_idx_q;
    num_ch_d  = num_ch_q;

    if (res_ok) out_cnt_d = out_cnt_q + CNT_ONE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_channels != '0) begin
            num_ch_d  = num_channels;
            ch_idx_d  = '0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = FEED;
          end else begin
            state_d = FIN;
          end
        end
      end
      FEED: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
          if (in_cnt_q == IN_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Compare the already-updated count so a result landing this cycle closes the channel.
        if (out_cnt_d >= OUT_TERM) begin
          in_cnt_d  = '0;
          out_cnt_d = '0;
          if (ch_idx_q == num_ch_q - CH_ONE) begin
            state_d = FIN;
          end else begin
            ch_idx_d = ch_idx_q + CH_ONE;
            state_d  = FEED;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      ch_idx_q      <= '0;
      num_ch_q      <= '0;
      done_q        <= 1'b0;
      core_sof_q    <= 1'b0;
      core_iv_q     <= 1'b0;
      core_d_in_q   <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      ch_idx_q    <= ch_idx_d;
      num_ch_q    <= num_ch_d;
      done_q      <= (state_q == FIN);
      core_iv_q   <= accept;
      core_sof_q  <= accept && (in_cnt_q == '0);
      if (accept) core_d_in_q <= src_data;
      out_valid_q <= res_ok;
      out_last_q  <= res_ok && (out_cnt_q == OUT_LAST);
      if (res_ok) begin
        out_data_q    <= core_d_out;
        out_channel_q <= ch_idx_q;
      end
    end
  end

  // Outputs are masked by rst so they read zero during the reset cycle itself.
  assign busy             = !rst && (state_q != IDLE);
  assign done             = !rst && done_q;
  assign src_ready        = !rst && (state_q == FEED);
  assign core_sof         = !rst && core_sof_q;
  assign core_input_valid = !rst && core_iv_q;
  assign core_d_in        = rst ? '0 : core_d_in_q;
  assign out_valid        = !rst && out_valid_q;
  assign out_last         = !rst && out_last_q;
  assign out_data         = rst ? '0 : out_data_q;
  assign out_channel      = rst ? '0 : out_channel_q;

endmodule

// File: tb/tb_pool_channel_scheduler.sv
// Scoreboard bench: expected results come from a frame-level max-pool model;
// a 5x5/3x3 stride-1 core model answers the DUT's feed stream.
module tb_pool_channel_scheduler;

  localparam int CHW = 8;
  localparam int FR  = 25;
  localparam int RES = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [CHW-1:0] num_channels = '0;
  logic           busy, done;
  logic           src_valid = 1'b0;
  logic           src_ready;
  logic [31:0]    src_data = '0;
  logic           core_sof, core_input_valid;
  logic [31:0]    core_d_in;
  logic           core_output_valid = 1'b0;
  logic [31:0]    core_d_out = '0;
  logic           out_valid;
  logic [31:0]    out_data;
  logic [CHW-1:0] out_channel;
  logic           out_last;

  pool_channel_scheduler #(
    .INPUT_X(5), .INPUT_Y(5), .OUT_X(3), .OUT_Y(3), .CH_WIDTH(CHW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_channels(num_channels),
    .busy(busy), .done(done),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .core_sof(core_sof), .core_input_valid(core_input_valid), .core_d_in(core_d_in),
    .core_output_valid(core_output_valid), .core_d_out(core_d_out),
    .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] src_q[$];
  logic [32:0] beat_q[$];
  logic [40:0] exp_q[$];
  int unsigned pend_due[$];
  logic [31:0] pend_dat[$];
  logic [31:0] frame[FR];
  int beat_cnt = 0;
  int vprob = 100;
  int delay = 0;
  bit force_cov = 1'b0;

  int res_cnt = 0, last_cnt = 0, sof_cnt = 0, done_cnt = 0, ready_cnt = 0;
  int unsigned done_cyc = 0;

  logic        s_busy, s_ready;
  logic [78:0] s_outs;
  logic [40:0] mon_e;
  logic [32:0] mon_b;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (core_input_valid) begin
      if (beat_q.size() == 0) chk("core_in_unexpected", core_input_valid, 0);
      else begin
        mon_b = beat_q.pop_front();
        chk("core_d_in", core_d_in, mon_b[31:0]);
        chk("core_sof", core_sof, mon_b[32]);
        if (core_sof) sof_cnt++;
      end
    end else if (core_sof) chk("core_sof_alone", core_sof, 0);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("out_unexpected", out_valid, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_result", {out_last, out_channel, out_data}, mon_e);
        res_cnt++;
        if (out_last) last_cnt++;
      end
    end
    if (src_ready) ready_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] win_max(input int r, input int c);
    logic [31:0] m = '0;
    for (int i = r - 2; i <= r; i++)
      for (int j = c - 2; j <= c; j++)
        if (frame[i*5 + j] > m) m = frame[i*5 + j];
    return m;
  endfunction

  // One clock: snapshot at negedge, then drive source and core model.
  task automatic run_cycle(input bit st, input logic [CHW-1:0] nch, input bit r);
    int bi;
    logic [31:0] d;
    @(negedge clk);
    s_busy  = busy;
    s_ready = src_ready;
    s_outs  = {busy, done, src_ready, core_sof, core_input_valid, out_valid, out_last,
               out_data, out_channel, core_d_in};
    #1;
    rst          = r;
    start        = st;
    num_channels = st ? nch : CHW'($urandom);
    src_valid    = 1'b0;
    src_data     = $urandom;
    if (!r && src_q.size() > 0 && $urandom_range(99) < vprob) begin
      src_valid = 1'b1;
      src_data  = src_q[0];
    end
    if (src_valid && s_ready) begin
      d  = src_q.pop_front();
      bi = beat_cnt % FR;
      frame[bi] = d;
      beat_q.push_back({(bi == 0), d});
      beat_cnt++;
      if (bi / 5 >= 2 && bi % 5 >= 2) begin
        pend_due.push_back(cyc + delay);
        pend_dat.push_back(win_max(bi / 5, bi % 5));
      end
    end
    core_output_valid = 1'b0;
    core_d_out        = $urandom;
    if (force_cov) core_output_valid = 1'b1;
    else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      core_output_valid = 1'b1;
      core_d_out        = pend_dat.pop_front();
      void'(pend_due.pop_front());
    end
  endtask

  task automatic run_job(input int nch, input int vp, input int dly, input int bstart_at, input int rst_at);
    int d0, o0, l0, s0, r0, t;
    int unsigned st_cyc;
    bit pulsed = 1'b0;
    bit st;
    logic [31:0] px[$];
    logic [31:0] m;
    d0 = done_cnt; o0 = res_cnt; l0 = last_cnt; s0 = sof_cnt; r0 = ready_cnt;
    beat_cnt = 0; vprob = vp; delay = dly;
    for (int i = 0; i < nch * FR; i++) px.push_back($urandom);
    foreach (px[i]) src_q.push_back(px[i]);
    for (int ch = 0; ch < nch; ch++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          m = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              if (px[ch*FR + (r+i)*5 + (c+j)] > m) m = px[ch*FR + (r+i)*5 + (c+j)];
          exp_q.push_back({(r == 2 && c == 2), CHW'(ch), m});
        end
    run_cycle(1'b1, CHW'(nch), 1'b0);
    st_cyc = cyc;
    run_cycle(1'b0, '0, 1'b0);
    chk("busy_after_start", s_busy, 1);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      if (rst_at >= 0 && beat_cnt == rst_at) begin
        run_cycle(1'b0, '0, 1'b1);
        src_q.delete(); exp_q.delete(); pend_due.delete(); pend_dat.delete();
        run_cycle(1'b0, '0, 1'b0);
        chk("outs_in_rst", s_outs, '0);
        run_cycle(1'b0, '0, 1'b0);
        chk("outs_after_rst", s_outs, '0);
        repeat (8) run_cycle(1'b0, '0, 1'b0);
        chk("no_done_after_rst", done_cnt - d0, 0);
        return;
      end
      st = (bstart_at >= 0 && beat_cnt >= bstart_at && !pulsed);
      if (st) pulsed = 1'b1;
      run_cycle(st, CHW'(5), 1'b0);
      t++;
    end
    repeat (10) run_cycle(1'b0, '0, 1'b0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("beats_accepted", beat_cnt, nch * FR);
    chk("results", res_cnt - o0, nch * RES);
    chk("out_lasts", last_cnt - l0, nch);
    chk("sof_count", sof_cnt - s0, nch);
    chk("exp_left", exp_q.size(), 0);
    chk("busy_at_end", s_busy, 0);
    if (nch == 0) begin
      chk("done_latency", done_cyc - st_cyc, 2);
      chk("ready_cycles", ready_cnt - r0, 0);
    end
    src_q.delete();
  endtask

  initial begin
    run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b0, '0, 1'b0);
    chk("reset_outputs", s_outs, '0);
    run_cycle(1'b0, '0, 1'b0);
    chk("idle_outputs", s_outs, '0);

    run_job(1, 100, 1, -1, -1);
    run_job(3, 60, 2, -1, -1);
    force_cov = 1'b1;
    repeat (3) run_cycle(1'b0, '0, 1'b0);
    run_job(0, 100, 0, -1, -1);
    force_cov = 1'b0;
    run_job(2, 80, 0, 10, -1);
    run_job(2, 100, 0, -1, 37);
    run_job(1, 100, 0, -1, -1);
    run_job(1, 100, 6, -1, -1);
    for (int k = 0; k < 4; k++)
      run_job($urandom_range(1, 3), $urandom_range(30, 100), $urandom_range(0, 5), -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/pool_channel_scheduler.md
POOL_CHANNEL_SCHEDULER -- requirements
Module: pool_channel_scheduler

Interface
REQ-001 Parameter INPUT_X, default 5, frame rows fed to the pooling core per channel.
REQ-002 Parameter INPUT_Y, default 5, frame columns fed to the pooling core per channel.
REQ-003 Parameter OUT_X, default 3, pooled rows produced by the core per channel.
REQ-004 Parameter OUT_Y, default 3, pooled columns produced by the core per channel.
REQ-005 Parameter CH_WIDTH, default 8, width of the channel count and index.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-009 num_channels  input  CH_WIDTH  channels in the job; sampled with start.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 done  output  1  one-cycle pulse at job end.
REQ-012 src_valid / src_ready / src_data  input / output / input(32)  pixel source handshake; a beat transfers when both valid and ready are high.
REQ-013 core_sof / core_input_valid / core_d_in  output / output / output(32)  drive the pooling core's sof, input_valid and d_in.
REQ-014 core_output_valid / core_d_out  input / input(32)  pooled result from the core.
REQ-015 out_valid / out_data / out_channel / out_last  output / output(32) / output(CH_WIDTH) / output(1)  tagged result stream.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, FEED, DRAIN and FIN.
REQ-017 In IDLE, start=1 with num_channels>0 SHALL latch num_channels, clear the channel index and both counters, and move to FEED.
REQ-018 In IDLE, start=1 with num_channels=0 SHALL move to FIN without feeding any data.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 src_ready SHALL equal (state==FEED) combinationally.
REQ-021 Each accepted source beat SHALL appear on core_d_in with core_input_valid=1 exactly one cycle later (registered); otherwise core_input_valid SHALL be 0.
REQ-022 core_sof SHALL be high together with core_input_valid on the first beat of each channel and low otherwise.
REQ-023 The input counter SHALL count accepted beats; acceptance of beat INPUT_X*INPUT_Y SHALL move FEED to DRAIN.
REQ-024 The output counter SHALL increment on every core_output_valid in FEED or DRAIN, because the core may emit results before feeding ends.
REQ-025 In DRAIN, once the output count reaches OUT_X*OUT_Y, the block SHALL either increment the channel index, clear both counters and return to FEED, or, on the last channel, move to FIN.
REQ-026 The output count update and the terminal-count compare SHALL use the same cycle's core_output_valid, so a final result arriving on the transition cycle is not lost.
REQ-027 FIN SHALL assert done for one cycle, then move to IDLE.
REQ-028 Each core_output_valid SHALL produce, one cycle later (registered):
  - out_valid=1
  - out_data=core_d_out
  - out_channel = current channel index
  - out_last=1 only for result OUT_X*OUT_Y of that channel
REQ-029 core_output_valid in IDLE or FIN SHALL be discarded: no out_valid and no count change.
REQ-030 Counters SHALL be wide enough for INPUT_X*INPUT_Y and SHALL never wrap within a channel.

Reset
REQ-031 rst SHALL force the FSM to IDLE and clear all counters, the channel index and the latched count.
REQ-032 While rst is high, busy, done, src_ready, core_sof, core_input_valid, out_valid and out_last SHALL be 0; out_data, out_channel and core_d_in SHALL be 0.
REQ-033 rst asserted mid-job SHALL abort the job with no done pulse, and the following cycle SHALL accept a new start.

Verification
REQ-034 Defaults, num_channels=1, src_valid held high, core modelled as 5x5 stride-1 -> exactly 25 beats accepted; core_sof on beat 1 only; 9 out_valid with out_channel=0; out_last on the 9th; one done pulse.
REQ-035 num_channels=3 with random src_valid gaps -> 75 beats; core_sof 3 times; out_channel 0,0..,1,..,2 in 9-result groups; out_last 3 times; done once.
REQ-036 num_channels=0 -> no src_ready, no core_input_valid; done pulses two cycles after start.
REQ-037 start pulsed again while busy -> ignored; the job completes with its original channel count.
REQ-038 rst asserted after beat 12 of channel 1 -> all outputs 0 the next cycle and no done pulse; a new start with num_channels=1 then completes normally.
REQ-039 Core emits its last result on the same cycle the 25th beat is accepted -> out_last still produced and the channel advances correctly.
